// File: rtl/clkgen_pkg.sv
// clkgen_pkg: shared state enum, phase width and phase decode sets for clock_reset_gen.
package clkgen_pkg;
    typedef enum logic [1:0] {ST_ASSERT, ST_WAIT_HIGH, ST_RUN} state_e;
    localparam int PHASE_W = 3;
    localparam logic [PHASE_W-1:0] PH_LAST = 3'd7;
    // Bit p of each set is 1 when the output is in its marked level at phase p.
    localparam logic [7:0] C1_LOW_PH = 8'b0000_1111;
    localparam logic [7:0] C3_LOW_PH = 8'b0011_1100;
    localparam logic [7:0] CLK7M_PH  = 8'b0011_0011;
    localparam logic [7:0] CDAC_PH   = 8'b0110_0110;
endpackage

// File: rtl/rst_stretch.sv
// rst_stretch: _RST sense synchronizer, stretch counter and ASSERT/WAIT_HIGH/RUN FSM.
import clkgen_pkg::*;
module rst_stretch #(
    parameter int RST_CYCLES = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               rst_sense_i,
    input  logic               kbreset_req_i,
    input  logic [PHASE_W-1:0] phase_i,
    output logic               rst_oe_o,
    output logic               sys_run_o
);
    localparam logic [15:0] RELOAD = 16'(RST_CYCLES);
    logic [1:0] sync_q;
    state_e     state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        sense;
    assign sense = sync_q[1];
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= 2'b00;
            state_q <= ST_ASSERT;
            cnt_q   <= RELOAD;
        end else begin
            sync_q  <= {sync_q[0], rst_sense_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    // The sense line is ignored in ASSERT because we are the ones pulling it low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_ASSERT: begin
                if (kbreset_req_i) cnt_d = RELOAD;
                else if (cnt_q == 16'd0) state_d = ST_WAIT_HIGH;
                else if (phase_i == PH_LAST) cnt_d = cnt_q - 16'd1;
            end
            ST_WAIT_HIGH: state_d = sense ? ST_RUN : ST_WAIT_HIGH;
            ST_RUN: begin
                if (kbreset_req_i || !sense) begin
                    state_d = ST_ASSERT;
                    cnt_d   = RELOAD;
                end
            end
            default: state_d = ST_ASSERT;
        endcase
    end
    assign rst_oe_o  = state_q == ST_ASSERT;
    assign sys_run_o = state_q == ST_RUN;
endmodule

// File: rtl/clock_reset_gen.sv
// clock_reset_gen: 8-phase clock decode from CLK_28M plus reset stretcher.
// CDAC is generated only when CLKGEN_CDAC_EN is defined; otherwise it is tied low.
import clkgen_pkg::*;
module clock_reset_gen #(
    parameter int RST_CYCLES = 16
) (
    input  logic CLK_28M,
    input  logic RST,
    input  logic RST_SENSE,
    input  logic KBRESET_REQ,
    output logic _C1,
    output logic _C3,
    output logic CLK_7M,
    output logic CDAC,
    output logic RST_OE,
    output logic SYS_RUN
);
    logic [PHASE_W-1:0] phase_q;
    logic c1_q, c3_q, clk7m_q;
    always_ff @(posedge CLK_28M) begin
        if (RST) begin
            phase_q <= '0;
            c1_q    <= 1'b1;
            c3_q    <= 1'b1;
            clk7m_q <= 1'b0;
        end else begin
            phase_q <= phase_q + 1'b1;
            c1_q    <= !C1_LOW_PH[phase_q];
            c3_q    <= !C3_LOW_PH[phase_q];
            clk7m_q <= CLK7M_PH[phase_q];
        end
    end
    assign _C1    = c1_q;
    assign _C3    = c3_q;
    assign CLK_7M = clk7m_q;
`ifdef CLKGEN_CDAC_EN
    logic cdac_q;
    always_ff @(posedge CLK_28M) begin
        if (RST) cdac_q <= 1'b0;
        else cdac_q <= CDAC_PH[phase_q];
    end
    assign CDAC = cdac_q;
`else
    assign CDAC = 1'b0;
`endif
    rst_stretch #(.RST_CYCLES(RST_CYCLES)) u_rst_stretch (
        .clk_i         (CLK_28M),
        .rst_i         (RST),
        .rst_sense_i   (RST_SENSE),
        .kbreset_req_i (KBRESET_REQ),
        .phase_i       (phase_q),
        .rst_oe_o      (RST_OE),
        .sys_run_o     (SYS_RUN)
    );
endmodule

// File: doc/clock_reset_gen.md
CLOCK_RESET_GEN -- requirements
Module: clock_reset_gen

Interface
REQ-001 Parameter: RST_CYCLES, default 16, reset-stretch length in C1 periods; legal range 1..65535.
REQ-002 CLK_28M  in  1  master clock (28.63636 MHz); the only clock.
REQ-003 RST  in  1  reset, synchronous and active-high.
REQ-004 RST_SENSE  in  1  level of shared open-drain _RST line (1 = released); asynchronous.
REQ-005 KBRESET_REQ  in  1  keyboard reset request, active-high level, synchronous to CLK_28M.
REQ-006 _C1  out  1  3.58 MHz phase clock, active-low naming.
REQ-007 _C3  out  1  _C1 delayed 90 degrees.
REQ-008 CLK_7M  out  1  7.16 MHz clock.
REQ-009 CDAC  out  1  CLK_7M delayed 90 degrees.
REQ-010 RST_OE  out  1  1 = pull _RST low (external bufif1 driver).
REQ-011 SYS_RUN  out  1  1 = stretcher in RUN.

Function
REQ-012 3-bit phase counter P SHALL increment by 1 every CLK_28M edge, wrapping 7->0.
REQ-013 All clock outputs SHALL be registered decodes of the current P (1-cycle latency), glitch-free.
REQ-014 Decode: _C1=0 for P in 0..3; _C3=0 for P in 2..5; CLK_7M=1 for P in {0,1,4,5}; CDAC=1 for P in {1,2,5,6}.
REQ-015 RST_SENSE SHALL pass a 2-flop synchronizer (reset value 0); only the synced value S is used.
REQ-016 Stretcher FSM states: ASSERT, WAIT_HIGH, RUN.
REQ-017 ASSERT: RST_OE=1; counter decrements once per C1 period, at P==7; at counter==0 go to WAIT_HIGH.
REQ-018 WAIT_HIGH: RST_OE=0; go to RUN on the first cycle S==1; remain indefinitely while S==0.
REQ-019 RUN: RST_OE=0, SYS_RUN=1; KBRESET_REQ==1 or S==0 -> ASSERT, counter reloaded to RST_CYCLES.
REQ-020 Simultaneous KBRESET_REQ and S==0 in RUN SHALL cause a single ASSERT entry.
REQ-021 KBRESET_REQ==1 while in ASSERT SHALL reload the counter to RST_CYCLES (extends the pulse).
REQ-022 S==0 while in ASSERT SHALL be ignored (self-driven).
REQ-023 Counter width SHALL be 16 bits; it SHALL never wrap below 0.

Reset
REQ-024 While RST=1: P=0, _C1=1, _C3=1, CLK_7M=0, CDAC=0, synchronizer=0, state=ASSERT, counter=RST_CYCLES, RST_OE=1, SYS_RUN=0.
REQ-025 First edge after RST falls: outputs decode P=0 and P becomes 1.
REQ-026 RST asserted mid-operation SHALL restart the full sequence from REQ-024 on the next edge, regardless of state.

Configuration
REQ-027 Macro CLKGEN_CDAC_EN defined: CDAC generated per REQ-014.
REQ-028 Macro CLKGEN_CDAC_EN undefined: CDAC constant 0 and its flop removed; all other behaviour unchanged.

Structure
REQ-029 Package clkgen_pkg SHALL hold the FSM state enum, the phase-width constant and the phase decode constants (C1/C3/7M/CDAC phase sets).
REQ-030 Stretcher FSM, counter and synchronizer SHALL live in sub-module rst_stretch; the phase counter and decode SHALL stay in clock_reset_gen.

Verification
REQ-031 RST high 5 cycles then low, RST_SENSE=1 -> 8-cycle periodic _C1 (low 4 / high 4), _C3 lagging by 2 cycles, CLK_7M period 4, CDAC lagging by 1.
REQ-032 Same stimulus, RST_CYCLES=16 -> RST_OE high for exactly 16 C1 periods after reset release, then SYS_RUN=1 within 3 cycles.
REQ-033 In RUN, pulse KBRESET_REQ for 1 cycle -> RST_OE=1 next edge for 16 C1 periods, SYS_RUN=0 throughout.
REQ-034 In RUN, hold RST_SENSE=0 for 200 cycles -> ASSERT for 16 periods, then WAIT_HIGH until RST_SENSE returns to 1 plus 2-cycle sync, then RUN.
REQ-035 KBRESET_REQ pulsed at C1 period 10 of ASSERT -> RST_OE total length 10+16 periods.
REQ-036 Build without CLKGEN_CDAC_EN -> CDAC stuck 0; REQ-031..035 results unchanged.
